truth_table_scanner: RTL and testbench

Sequential exhaustive-stimulus and capture stage wrapped around the team's 4-input, two-function Boolean minimization block. It steps a 4-bit minterm index through all 16 values and drives that index onto the block's {a,b,c,d} and {w,x,y,z} inputs. After a programmable settle time it samples f1/f2, builds both 16-bit truth tables, and compares them against expected tables to report a match flag and a mismatch count.

---
 rtl/truth_table_scanner_pkg.sv | 11 +
 rtl/truth_table_scanner_if.sv | 25 ++
 rtl/truth_table_scanner_popcount.sv | 12 +
 rtl/truth_table_scanner.sv | 86 ++++++++
 tb/tb_truth_table_scanner.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared widths and FSM state encodings for the scanner
package truth_table_scanner_pkg;
  localparam int TT_W = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 6;
  localparam int SETTLE_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: control, stimulus-drive and result bundle of the scanner
interface truth_table_scanner_if;
  import truth_table_scanner_pkg::*;
  logic start;
  logic [TT_W-1:0] exp_f1;
  logic [TT_W-1:0] exp_f2;
  logic f1_in;
  logic f2_in;
  logic [IDX_W-1:0] drive_abcd;
  logic [IDX_W-1:0] drive_wxyz;
  logic busy;
  logic done;
  logic [TT_W-1:0] tt_f1;
  logic [TT_W-1:0] tt_f2;
  logic match;
  logic [CNT_W-1:0] mismatch_cnt;
  modport master(
    output start, exp_f1, exp_f2, f1_in, f2_in,
    input drive_abcd, drive_wxyz, busy, done, tt_f1, tt_f2, match, mismatch_cnt
  );
  modport slave(
    input start, exp_f1, exp_f2, f1_in, f2_in,
    output drive_abcd, drive_wxyz, busy, done, tt_f1, tt_f2, match, mismatch_cnt
  );
endinterface

// File: rtl/truth_table_scanner_popcount.sv
// tt_popcount16: combinational population count of a 16-bit vector
module tt_popcount16
  import truth_table_scanner_pkg::*;
(
  input  logic [TT_W-1:0] i_vec,
  output logic [4:0]      o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < TT_W; i++) o_cnt = o_cnt + 5'(i_vec[i]);
  end
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks all 16 minterms, captures f1/f2 truth tables and scores them against expected tables
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  truth_table_scanner_if.slave bus
);
  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [SETTLE_W-1:0] r_cnt;
  logic [TT_W-1:0]     r_exp_f1;
  logic [TT_W-1:0]     r_exp_f2;
  logic [TT_W-1:0]     r_tt_f1;
  logic [TT_W-1:0]     r_tt_f2;
  logic                r_match;
  logic [CNT_W-1:0]    r_mis;
  logic [TT_W-1:0]     w_tt_f1_n;
  logic [TT_W-1:0]     w_tt_f2_n;
  logic [4:0]          w_pc1;
  logic [4:0]          w_pc2;
  logic [CNT_W-1:0]    w_sum;
  logic                w_active;
  // Score the tables as they will be after this SAMPLE edge, so the result lands together with done
  assign w_tt_f1_n = (r_tt_f1 & ~(TT_W'(1) << r_idx)) | (TT_W'(bus.f1_in) << r_idx);
  assign w_tt_f2_n = (r_tt_f2 & ~(TT_W'(1) << r_idx)) | (TT_W'(bus.f2_in) << r_idx);
  tt_popcount16 u_pc1 (.i_vec(w_tt_f1_n ^ r_exp_f1), .o_cnt(w_pc1));
  tt_popcount16 u_pc2 (.i_vec(w_tt_f2_n ^ r_exp_f2), .o_cnt(w_pc2));
  assign w_sum = CNT_W'(w_pc1) + CNT_W'(w_pc2);
  assign w_active = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign bus.drive_abcd = w_active ? r_idx : '0;
  assign bus.drive_wxyz = bus.drive_abcd;
  assign bus.busy = w_active;
  assign bus.done = r_state == ST_DONE;
  assign bus.tt_f1 = r_tt_f1;
  assign bus.tt_f2 = r_tt_f2;
  assign bus.match = r_match;
  assign bus.mismatch_cnt = r_mis;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_exp_f1 <= '0;
      r_exp_f2 <= '0;
      r_tt_f1 <= '0;
      r_tt_f2 <= '0;
      r_match <= 1'b0;
      r_mis <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_state <= ST_SETTLE;
          r_idx <= '0;
          r_cnt <= SETTLE_W'(SETTLE_CYCLES);
          r_exp_f1 <= bus.exp_f1;
          r_exp_f2 <= bus.exp_f2;
          r_tt_f1 <= '0;
          r_tt_f2 <= '0;
          r_match <= 1'b0;
          r_mis <= '0;
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - SETTLE_W'(1);
          if (r_cnt == SETTLE_W'(1)) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_tt_f1 <= w_tt_f1_n;
          r_tt_f2 <= w_tt_f2_n;
          if (r_idx == '1) begin
            r_state <= ST_DONE;
            r_match <= w_sum == '0;
            r_mis <= w_sum;
          end else begin
            r_state <= ST_SETTLE;
            r_idx <= r_idx + IDX_W'(1);
            r_cnt <= SETTLE_W'(SETTLE_CYCLES);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboarded directed scans on three scanners (settle 1, 3 and 2)
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;
  typedef struct {
    logic [15:0] t1;
    logic [15:0] t2;
    logic        m;
    logic [5:0]  c;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int m1[3];
  int m2[3];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  truth_table_scanner_if if0 ();
  truth_table_scanner_if if1 ();
  truth_table_scanner_if if2 ();
  truth_table_scanner #(.SETTLE_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  truth_table_scanner #(.SETTLE_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
  truth_table_scanner #(.SETTLE_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Function-block model: 0 -> const 0, 1 -> d, 2 -> ~d, 3 -> const 1, 4 -> a
  function automatic logic fv(int m, logic [3:0] d);
    return m == 1 ? d[0] : m == 2 ? ~d[0] : m == 3 ? 1'b1 : m == 4 ? d[3] : 1'b0;
  endfunction
  always_comb begin
    if0.f1_in = fv(m1[0], if0.drive_abcd);
    if0.f2_in = fv(m2[0], if0.drive_abcd);
    if1.f1_in = fv(m1[1], if1.drive_abcd);
    if1.f2_in = fv(m2[1], if1.drive_abcd);
    if2.f1_in = fv(m1[2], if2.drive_abcd);
    if2.f2_in = fv(m2[2], if2.drive_abcd);
  end
  function automatic void chk(string n, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, act, expv);
    end
  endfunction
  function automatic void score(string n, exp_t e, logic [15:0] t1, logic [15:0] t2, logic m,
                                logic [5:0] c, logic b, logic [3:0] dr);
    chk({n, " done cycle"}, cyc, e.cyc);
    chk({n, " tt_f1"}, 32'(t1), 32'(e.t1));
    chk({n, " tt_f2"}, 32'(t2), 32'(e.t2));
    chk({n, " match"}, 32'(m), 32'(e.m));
    chk({n, " mismatch_cnt"}, 32'(c), 32'(e.c));
    chk({n, " busy in done"}, 32'(b), 0);
    chk({n, " drive in done"}, 32'(dr), 0);
  endfunction
  function automatic void spurious(string n);
    checks++;
    errors++;
    $display("FAIL %s spurious done at cycle %0d: got done=1, expected no done", n, cyc);
  endfunction
  always @(negedge clk) if (if0.done === 1'b1) begin
    if (q0.size() == 0) spurious("u0");
    else score("u0", q0.pop_front(), if0.tt_f1, if0.tt_f2, if0.match, if0.mismatch_cnt, if0.busy, if0.drive_abcd);
  end
  always @(negedge clk) if (if1.done === 1'b1) begin
    if (q1.size() == 0) spurious("u1");
    else score("u1", q1.pop_front(), if1.tt_f1, if1.tt_f2, if1.match, if1.mismatch_cnt, if1.busy, if1.drive_abcd);
  end
  always @(negedge clk) if (if2.done === 1'b1) begin
    if (q2.size() == 0) spurious("u2");
    else score("u2", q2.pop_front(), if2.tt_f1, if2.tt_f2, if2.match, if2.mismatch_cnt, if2.busy, if2.drive_abcd);
  end
  // Called at a negedge: start is taken at the next posedge E0, done is due at E0 + 16*(S+1)
  task automatic start_scan(int u, logic [15:0] e1, logic [15:0] e2, exp_t ex);
    ex.cyc = cyc + 1 + 16 * ((u == 0 ? 1 : u == 1 ? 3 : 2) + 1);
    case (u)
      0: begin q0.push_back(ex); if0.exp_f1 = e1; if0.exp_f2 = e2; if0.start = 1'b1; end
      1: begin q1.push_back(ex); if1.exp_f1 = e1; if1.exp_f2 = e2; if1.start = 1'b1; end
      default: begin q2.push_back(ex); if2.exp_f1 = e1; if2.exp_f2 = e2; if2.start = 1'b1; end
    endcase
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
  endtask
  task automatic wait_done(int u);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((u == 0 ? if0.done : u == 1 ? if1.done : if2.done) === 1'b1) return;
    end
    chk($sformatf("u%0d done timeout", u), 0, 1);
  endtask
  task automatic wait_idx0(logic [3:0] k);
    for (int i = 0; i < 100; i++) begin
      if (if0.busy === 1'b1 && if0.drive_abcd === k) return;
      @(negedge clk);
    end
    chk("u0 index wait timeout", 0, 1);
  endtask
  task automatic chk_zero0(string n);
    chk({n, " drive_abcd"}, 32'(if0.drive_abcd), 0);
    chk({n, " drive_wxyz"}, 32'(if0.drive_wxyz), 0);
    chk({n, " busy"}, 32'(if0.busy), 0);
    chk({n, " done"}, 32'(if0.done), 0);
    chk({n, " tt_f1"}, 32'(if0.tt_f1), 0);
    chk({n, " tt_f2"}, 32'(if0.tt_f2), 0);
    chk({n, " match"}, 32'(if0.match), 0);
    chk({n, " mismatch_cnt"}, 32'(if0.mismatch_cnt), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    {if0.start, if1.start, if2.start} = '0;
    {if0.exp_f1, if0.exp_f2, if1.exp_f1, if1.exp_f2, if2.exp_f1, if2.exp_f2} = '0;
    m1 = '{1, 0, 1};
    m2 = '{3, 4, 3};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero0("reset");
    // Full-table match, S=1
    start_scan(0, 16'hAAAA, 16'hFFFF, '{16'hAAAA, 16'hFFFF, 1'b1, 6'd0, 0});
    wait_done(0);
    @(negedge clk);
    chk("hold after done tt_f1", 32'(if0.tt_f1), 32'hAAAA);
    chk("hold after done match", 32'(if0.match), 1);
    // Counting mismatches, S=3
    start_scan(1, 16'hFFFF, 16'h0000, '{16'h0000, 16'hFF00, 1'b0, 6'd24, 0});
    wait_done(1);
    // Drive sequencing, S=2: each index held 3 cycles, abcd == wxyz
    start_scan(2, 16'hAAAA, 16'hFFFF, '{16'hAAAA, 16'hFFFF, 1'b1, 6'd0, 0});
    for (int j = 0; j < 48; j++) begin
      chk($sformatf("seq drive_abcd j=%0d", j), 32'(if2.drive_abcd), 32'(j / 3));
      chk($sformatf("seq drive_wxyz j=%0d", j), 32'(if2.drive_wxyz), 32'(j / 3));
      chk($sformatf("seq busy j=%0d", j), 32'(if2.busy), 1);
      @(negedge clk);
    end
    chk("seq done after 48 cycles", 32'(if2.done), 1);
    chk("seq drive in done", 32'(if2.drive_abcd), 0);
    @(negedge clk);
    // Start while busy: pulse at index 7 with different expectations; must be dropped
    start_scan(0, 16'hAAAA, 16'hFFFF, '{16'hAAAA, 16'hFFFF, 1'b1, 6'd0, 0});
    wait_idx0(4'd7);
    if0.exp_f1 = 16'h1234;
    if0.exp_f2 = 16'h0000;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done(0);
    @(negedge clk);
    // Reset mid-scan at index 9, with a start that rst must swallow
    start_scan(0, 16'hAAAA, 16'hFFFF, '{16'hAAAA, 16'hFFFF, 1'b1, 6'd0, 0});
    wait_idx0(4'd9);
    rst = 1'b1;
    if0.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if0.start = 1'b0;
    q0.delete();
    chk_zero0("mid-scan reset");
    @(negedge clk);
    chk("start lost under reset busy", 32'(if0.busy), 0);
    start_scan(0, 16'hAAAA, 16'hFFFF, '{16'hAAAA, 16'hFFFF, 1'b1, 6'd0, 0});
    wait_done(0);
    @(negedge clk);
    // Back-to-back: first scan mismatches f1, second uses inverted f1 and matches
    start_scan(0, 16'h5555, 16'hFFFF, '{16'hAAAA, 16'hFFFF, 1'b0, 6'd16, 0});
    wait_done(0);
    m1[0] = 2;
    @(negedge clk);
    start_scan(0, 16'h5555, 16'hFFFF, '{16'h5555, 16'hFFFF, 1'b1, 6'd0, 0});
    chk("b2b tt_f1 cleared", 32'(if0.tt_f1), 0);
    chk("b2b match cleared", 32'(if0.match), 0);
    chk("b2b mismatch_cnt cleared", 32'(if0.mismatch_cnt), 0);
    chk("b2b busy", 32'(if0.busy), 1);
    wait_done(0);
    repeat (4) @(negedge clk);
    chk("u0 scoreboard drained", q0.size(), 0);
    chk("u1 scoreboard drained", q1.size(), 0);
    chk("u2 scoreboard drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
